// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Arbitration policy is selected by the ARB_ROUND_ROBIN_EN macro (see mem_arb_pick).
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 128;

  // Memory acts on a rising edge only while its stage input equals this value
  localparam logic [2:0] MEM_STAGE_ACCESS = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, grouped for connection.
// slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              err;
  logic              busy;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_stage;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, err, busy,
           mem_write, mem_read, mem_addr, mem_wdata, mem_stage
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, err, busy,
           mem_write, mem_read, mem_addr, mem_wdata, mem_stage
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant select. Fixed priority (D over I) by default;
// ARB_ROUND_ROBIN_EN grants the port not granted last on contention.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  port_e last_grant,
`endif
  output logic  valid_c,
  output port_e grant_c
);

  always_comb begin
    valid_c = i_req | d_req;
    grant_c = PORT_I;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_c = (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
      grant_c = PORT_D;
`endif
    end else if (d_req) begin
      grant_c = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) through an
// IDLE -> ISSUE -> RESP sequence. Policy macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  logic              we_q, we_d;
  logic              rej_q, rej_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_stage_q, mem_stage_d;

  logic              pick_valid;
  port_e             pick_grant;

`ifdef ARB_ROUND_ROBIN_EN
  port_e             last_grant_q, last_grant_d;
`endif

  mem_arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .valid_c    (pick_valid),
    .grant_c    (pick_grant)
  );

  // Next state, request latch and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    rej_d   = rej_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick_grant;
`endif
          if (pick_grant == PORT_D) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.i_addr;
            wdata_d = '0;
          end
          // Out-of-range addresses never reach the memory
          rej_d   = !addr_in_range(32'(addr_d), DEPTH);
          state_d = rej_d ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    mem_stage_d = (state_d == ISSUE) ? MEM_STAGE_ACCESS : 3'd0;
    mem_write_d = (state_d == ISSUE) &&  we_d;
    mem_read_d  = (state_d == ISSUE) && !we_d;
    mem_addr_d  = (state_d == ISSUE) ? addr_d  : '0;
    mem_wdata_d = (state_d == ISSUE) ? wdata_d : '0;
    i_ack_d     = (state_d == RESP) && (grant_d == PORT_I);
    d_ack_d     = (state_d == RESP) && (grant_d == PORT_D);
    err_d       = (state_d == RESP) && rej_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= PORT_I;
      we_q        <= 1'b0;
      rej_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_stage_q <= 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_I;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      rej_q       <= rej_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_stage_q <= mem_stage_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_stage = mem_stage_q;

  // Memory output only changes in stage 3, so it is stable for the whole RESP cycle
  assign bus.i_rdata = (i_ack_q && !rej_q)          ? bus.mem_rdata : '0;
  assign bus.d_rdata = (d_ack_q && !rej_q && !we_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences and
// random single accesses against a word-array reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned DEP = 128;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory device: acts on a rising edge only in stage 3
  logic [DW-1:0] mem [DEP];
  logic [DW-1:0] mem_rdata_r = '0;
  assign bus.mem_rdata = mem_rdata_r;
  always @(posedge clock) begin
    if (bus.mem_stage == 3'd3) begin
      if (bus.mem_write && bus.mem_addr < AW'(DEP)) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
      if (bus.mem_read) mem_rdata_r <= (bus.mem_addr < AW'(DEP)) ? mem[bus.mem_addr[6:0]] : '0;
    end
  end

  // Reference model of memory contents
  logic [DW-1:0] ref_mem [DEP];

  int n_cmp = 0;
  int n_mis = 0;
  int exp_acks = 0;
  int mon_acks = 0;
  int mon_wr = 0;
  int mon_rd = 0;
  int mon_stage = 0;
  int mon_both = 0;

  always @(posedge clock) begin
    if (bus.i_ack) mon_acks++;
    if (bus.d_ack) mon_acks++;
    if (bus.mem_write) mon_wr++;
    if (bus.mem_read) mon_rd++;
    if (bus.mem_stage == 3'd3) mon_stage++;
    if (bus.mem_write && bus.mem_read) mon_both++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // One access from IDLE; starts and ends at a negedge with the FSM idle
  task automatic run_access(input string name, input bit port, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic [DW-1:0] exp_rd, got_rd;
    bit exp_err, got_err, other;
    int lat, wr0, rd0, st0;
    exp_err = (addr >= AW'(DEP));
    exp_rd  = (exp_err || (port && we)) ? '0 : ref_mem[addr[6:0]];
    wr0 = mon_wr; rd0 = mon_rd; st0 = mon_stage;
    if (port) begin
      bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end
    exp_acks++;
    lat = 0; other = 1'b0; got_rd = '0; got_err = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (port ? bus.i_ack : bus.d_ack) other = 1'b1;
      if (port ? bus.d_ack : bus.i_ack) begin
        lat = c;
        got_rd = port ? bus.d_rdata : bus.i_rdata;
        got_err = bus.err;
        break;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    cyc();
    check({name, " latency"}, 64'(lat), exp_err ? 64'd1 : 64'd2);
    check({name, " rdata"}, 64'(got_rd), 64'(exp_rd));
    check({name, " err"}, 64'(got_err), 64'(exp_err));
    check({name, " other ack"}, 64'(other), 64'd0);
    check({name, " stage3 cycles"}, 64'(mon_stage - st0), exp_err ? 64'd0 : 64'd1);
    check({name, " write cycles"}, 64'(mon_wr - wr0), (!exp_err && port && we) ? 64'd1 : 64'd0);
    check({name, " read cycles"}, 64'(mon_rd - rd0), (!exp_err && !(port && we)) ? 64'd1 : 64'd0);
    if (port && we && !exp_err) ref_mem[addr[6:0]] = wdata;
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [DW-1:0] rd_obs;
    int got, mism, a0;
    int exp_order [4];

    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < int'(DEP); i++) begin
      mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    vecs[0] = '{0, 0, 8'd5,   32'h0,         32'hDEAD_BEEF, 0};
    vecs[1] = '{1, 1, 8'd10,  32'h1234,      32'h0,         0};
    vecs[2] = '{1, 0, 8'd10,  32'h0,         32'h1234,      0};
    vecs[3] = '{0, 0, 8'd10,  32'h0,         32'h1234,      0};
    vecs[4] = '{1, 1, 8'd128, 32'hCAFE,      32'h0,         1};
    vecs[5] = '{1, 0, 8'd200, 32'h0,         32'h0,         1};
    vecs[6] = '{0, 0, 8'd255, 32'h0,         32'h0,         1};
    vecs[7] = '{1, 1, 8'd127, 32'hA5A5_A5A5, 32'h0,         0};
    vecs[8] = '{0, 0, 8'd127, 32'h0,         32'hA5A5_A5A5, 0};
    vecs[9] = '{1, 0, 8'd0,   32'h0,         32'h1000_0000, 0};

    // Reset state
    #2;
    check("reset outputs", 64'({bus.i_ack, bus.d_ack, bus.err, bus.busy, bus.mem_write,
          bus.mem_read, bus.mem_stage}), 64'd0);
    check("reset rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Reset asserted during ISSUE of a store: no ack, store not performed
    bus.d_we = 1; bus.d_addr = 8'd20; bus.d_wdata = 32'hFFFF_0000; bus.d_req = 1;
    cyc();
    check("pre-reset stage", 64'(bus.mem_stage), 64'd3);
    a0 = mon_acks;
    reset_n = 1'b0;
    #1;
    check("mid-issue reset outputs", 64'({bus.i_ack, bus.d_ack, bus.err, bus.mem_write,
          bus.mem_read, bus.mem_stage, bus.mem_addr}), 64'd0);
    check("mid-issue reset busy", 64'(bus.busy), 64'd0);
    bus.d_req = 0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc(); cyc(); cyc();
    check("no ack after reset", 64'(mon_acks - a0), 64'd0);
    run_access("aborted store not written", 1, 0, 8'd20, 32'h0);

    // Vector table
    for (int v = 0; v < 10; v++) begin
      check($sformatf("vec%0d expected rdata", v), 64'(vecs[v].exp_rdata),
            64'((vecs[v].exp_err || (vecs[v].port && vecs[v].we)) ? '0 : ref_mem[vecs[v].addr[6:0]]));
      run_access($sformatf("vec%0d", v), vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata);
    end

    // Constant contention after reset
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    bus.i_addr = 8'd5; bus.d_we = 0; bus.d_addr = 8'd10;
    bus.i_req = 1; bus.d_req = 1;
    for (int k = 0; k < 4; k++) begin
      got = -1; rd_obs = '0;
      for (int c = 0; c < 8; c++) begin
        cyc();
        if (bus.i_ack || bus.d_ack) begin
          got = (bus.i_ack && bus.d_ack) ? 2 : (bus.d_ack ? 1 : 0);
          rd_obs = bus.d_ack ? bus.d_rdata : bus.i_rdata;
          break;
        end
      end
      exp_acks++;
      check($sformatf("contention grant %0d", k), 64'(got), 64'(exp_order[k]));
      check($sformatf("contention rdata %0d", k), 64'(rd_obs),
            64'(exp_order[k] == 1 ? ref_mem[10] : ref_mem[5]));
    end
    bus.i_req = 0; bus.d_req = 0;
    cyc();

    // Request raised during the other port's ISSUE waits for IDLE
    bus.d_we = 0; bus.d_addr = 8'd3; bus.d_req = 1;
    cyc();
    check("hold issue stage", 64'(bus.mem_stage), 64'd3);
    bus.i_addr = 8'd7; bus.i_req = 1;
    cyc();
    check("hold d_ack", 64'({bus.d_ack, bus.i_ack}), 64'b10);
    check("hold d_rdata", 64'(bus.d_rdata), 64'(ref_mem[3]));
    bus.d_req = 0;
    exp_acks++;
    cyc();
    check("hold idle gap", 64'({bus.busy, bus.i_ack, bus.d_ack}), 64'd0);
    cyc();
    check("hold i issue", 64'({bus.mem_stage, bus.mem_addr}), 64'({3'd3, 8'd7}));
    cyc();
    check("hold i_ack", 64'({bus.i_ack, bus.d_ack}), 64'b10);
    check("hold i_rdata", 64'(bus.i_rdata), 64'(ref_mem[7]));
    bus.i_req = 0;
    exp_acks++;
    cyc();

    // Random single accesses against the reference model
    for (int r = 0; r < 150; r++) begin
      run_access($sformatf("rand%0d", r), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 AW'($urandom_range(140)), $urandom);
    end

    check("ack count", 64'(mon_acks), 64'(exp_acks));
    check("write and read together", 64'(mon_both), 64'd0);
    mism = 0;
    for (int i = 0; i < int'(DEP); i++) if (mem[i] !== ref_mem[i]) mism++;
    check("memory contents", 64'(mism), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
